irda_mir_tx_framer: RTL

- MIR (1.152 Mbit/s) HDLC transmit framer; sits directly downstream of the MIR TX data controller.
- Consumes its un-stuffed serial bit (data bit plus data-available) and requests the next bit with a one-clock next_data strobe.
- Emits START_FLAGS opening flags (0x7E), the data bits with zero-bit insertion, CRC-16 FCS (stuffed) and one closing flag, one bit per bit-rate strobe.
- Output is an NRZ bit stream feeding the MIR pulse encoder.

---
 rtl/irda_mir_tx_framer_if.sv | 35 +++
 rtl/irda_mir_tx_framer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/irda_mir_tx_framer_if.sv
// Bundle of control, data-controller handshake and serial output signals
// for the MIR HDLC transmit framer.
//   slave  : framer side (consumes control/data, drives handshake + bit stream)
//   master : controlling side (data controller, sequencer, bench)
// Signals:
//   mir_tx_enabled, tx_bit_en, tx_start, frame_len  : control into framer
//   data_i, data_available                          : un-stuffed data bit in
//   next_data, dc_restart                           : data controller handshake
//   tx_bit_o, tx_active, frame_done, tx_underrun    : framer status / output
interface irda_mir_tx_framer_if #(
  parameter int LEN_W = 12
) ();
  logic             mir_tx_enabled;
  logic             tx_bit_en;
  logic             tx_start;
  logic [LEN_W-1:0] frame_len;
  logic             data_i;
  logic             data_available;
  logic             next_data;
  logic             dc_restart;
  logic             tx_bit_o;
  logic             tx_active;
  logic             frame_done;
  logic             tx_underrun;

  modport slave (
    input  mir_tx_enabled, tx_bit_en, tx_start, frame_len, data_i, data_available,
    output next_data, dc_restart, tx_bit_o, tx_active, frame_done, tx_underrun
  );

  modport master (
    output mir_tx_enabled, tx_bit_en, tx_start, frame_len, data_i, data_available,
    input  next_data, dc_restart, tx_bit_o, tx_active, frame_done, tx_underrun
  );
endinterface

// File: rtl/irda_mir_tx_framer.sv
// MIR (1.152 Mbit/s) HDLC transmit framer. Sends START_FLAGS opening 0x7E
// flags, the payload with zero-bit insertion, the stuffed CRC-16 FCS and one
// closing flag, one NRZ bit per tx_bit_en strobe.
// Ports:
//   clk      : system clock
//   wb_rst_i : asynchronous active-high reset
//   bus      : irda_mir_tx_framer_if.slave (control, data handshake, output)
//
// state | meaning
// IDLE  | waiting for tx_start, line held at 0
// SFLAG | opening flags, unstuffed
// DATA  | payload bits with zero-bit insertion and CRC update
// FCS   | inverted CRC, LSB first, stuffed
// EFLAG | closing flag, unstuffed
// ABORT | data underrun, eight 1s then back to IDLE
module irda_mir_tx_framer #(
  parameter int START_FLAGS = 2,
  parameter int LEN_W       = 12
) (
  input  logic clk,
  input  logic wb_rst_i,
  irda_mir_tx_framer_if.slave bus
);
  localparam logic [7:0]       FLAG       = 8'h7E;
  localparam int               CNT_W      = 7;
  localparam logic [CNT_W-1:0] SFLAG_LAST = CNT_W'(START_FLAGS * 8 - 1);
  localparam logic [LEN_W+2:0] BITS_ZERO  = '0;
  localparam logic [LEN_W+2:0] BITS_ONE   = (LEN_W+3)'(1);

  typedef enum logic [2:0] {IDLE, SFLAG, DATA, FCS, EFLAG, ABORT} state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W+2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_ones, w_ones_nxt;
  logic [15:0]      r_crc, w_crc_nxt;
  logic             r_tx_bit, w_tx_bit_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_dc_restart, w_dc_restart_nxt;
  logic             r_underrun, w_underrun_nxt;
  logic             w_next_data;
  logic             w_crc_fb;
  logic             w_fcs_bit;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_cnt        <= '0;
      r_ones       <= '0;
      r_crc        <= 16'hFFFF;
      r_tx_bit     <= 1'b0;
      r_frame_done <= 1'b0;
      r_dc_restart <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ones       <= w_ones_nxt;
      r_crc        <= w_crc_nxt;
      r_tx_bit     <= w_tx_bit_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_dc_restart <= w_dc_restart_nxt;
      r_underrun   <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_cnt_nxt        = r_cnt;
    w_ones_nxt       = r_ones;
    w_crc_nxt        = r_crc;
    w_tx_bit_nxt     = r_tx_bit;
    w_frame_done_nxt = 1'b0;
    w_dc_restart_nxt = 1'b0;
    w_underrun_nxt   = 1'b0;
    w_next_data      = 1'b0;
    w_crc_fb         = bus.data_i ^ r_crc[0];
    w_fcs_bit        = ~r_crc[0];

    if (r_state != IDLE && !bus.mir_tx_enabled) begin
      // Mode switched away mid-frame: drop the line and resync the data side.
      w_state_nxt      = IDLE;
      w_tx_bit_nxt     = 1'b0;
      w_cnt_nxt        = '0;
      w_dc_restart_nxt = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // The last abort '1' keeps its full bit period before the line idles.
          if (bus.tx_bit_en) w_tx_bit_nxt = 1'b0;
          if (bus.tx_start && bus.mir_tx_enabled) begin
            w_state_nxt   = SFLAG;
            w_bit_cnt_nxt = {bus.frame_len, 3'b000};
            w_crc_nxt     = 16'hFFFF;
            w_ones_nxt    = '0;
            w_cnt_nxt     = '0;
          end
        end
        SFLAG: if (bus.tx_bit_en) begin
          w_tx_bit_nxt = FLAG[r_cnt[2:0]];
          w_cnt_nxt    = r_cnt + 1'b1;
          if (r_cnt == SFLAG_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_bit_cnt == BITS_ZERO) ? FCS : DATA;
          end
        end
        DATA: if (bus.tx_bit_en) begin
          if (r_ones == 3'd5) begin
            w_tx_bit_nxt = 1'b0;
            w_ones_nxt   = '0;
            if (r_bit_cnt == BITS_ZERO) w_state_nxt = FCS;
          end else if (!bus.data_available) begin
            w_state_nxt    = ABORT;
            w_underrun_nxt = 1'b1;
            w_cnt_nxt      = '0;
          end else begin
            w_next_data   = 1'b1;
            w_tx_bit_nxt  = bus.data_i;
            w_crc_nxt     = {1'b0, r_crc[15:1]} ^ (w_crc_fb ? 16'h8408 : 16'h0000);
            w_ones_nxt    = bus.data_i ? 3'(r_ones + 3'd1) : 3'd0;
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
            // Stay in DATA for one more strobe if the last bit leaves a stuff pending.
            if (r_bit_cnt == BITS_ONE && w_ones_nxt != 3'd5) w_state_nxt = FCS;
          end
        end
        FCS: if (bus.tx_bit_en) begin
          if (r_ones == 3'd5) begin
            w_tx_bit_nxt = 1'b0;
            w_ones_nxt   = '0;
            if (r_cnt == CNT_W'(16)) begin
              w_state_nxt = EFLAG;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_tx_bit_nxt = w_fcs_bit;
            w_crc_nxt    = {1'b1, r_crc[15:1]};
            w_ones_nxt   = w_fcs_bit ? 3'(r_ones + 3'd1) : 3'd0;
            w_cnt_nxt    = r_cnt + 1'b1;
            if (r_cnt == CNT_W'(15) && w_ones_nxt != 3'd5) begin
              w_state_nxt = EFLAG;
              w_cnt_nxt   = '0;
            end
          end
        end
        EFLAG: if (bus.tx_bit_en) begin
          w_tx_bit_nxt = FLAG[r_cnt[2:0]];
          w_cnt_nxt    = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(7)) begin
            w_state_nxt      = IDLE;
            w_cnt_nxt        = '0;
            w_frame_done_nxt = 1'b1;
            w_dc_restart_nxt = 1'b1;
          end
        end
        ABORT: if (bus.tx_bit_en) begin
          w_tx_bit_nxt = 1'b1;
          w_cnt_nxt    = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(7)) begin
            w_state_nxt      = IDLE;
            w_cnt_nxt        = '0;
            w_dc_restart_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.next_data   = w_next_data;
  assign bus.dc_restart  = r_dc_restart;
  assign bus.tx_bit_o    = r_tx_bit;
  assign bus.tx_active   = (r_state != IDLE);
  assign bus.frame_done  = r_frame_done;
  assign bus.tx_underrun = r_underrun;
endmodule
